// File: rtl/intr_pkg.sv
// intr_pkg -- shared definitions for the interrupt controller.
//   State encoding for the request FSM (legacy-compatible localparams) and
//   the default I/O port addresses used by intr_ctrl.
package intr_pkg;

   // Request FSM state encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_ASSERT  = 2'd1;
   localparam state_t ST_SERVICE = 2'd2;

   // Default IN/OUT port addresses
   localparam logic [7:0] MASK_PORT_DEF = 8'h30;
   localparam logic [7:0] CLR_PORT_DEF  = 8'h31;
   localparam logic [7:0] STAT_PORT_DEF = 8'h32;
   localparam logic [7:0] ID_PORT_DEF   = 8'h33;

endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge -- one request line: 2-flop synchronizer plus history flop
// and rising-edge detector.
//   clk     : system clock
//   reset_n : synchronous active-low reset (clears all three flops)
//   src     : raw asynchronous request line
//   rise    : one-cycle pulse when the synchronized line goes 0 -> 1
// Because the history flop resets to 0, a line already high when reset is
// released is reported as a rising edge.
module irq_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic src,
   output logic rise
);

   logic s1, s2, s3;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, forming a real shift chain.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= src;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl -- interrupt controller feeding the MCU control unit.
//   Latches rising edges of up to N_SRC request lines as pending bits and
//   issues a one-cycle 'interrupt' pulse when an enabled source is pending
//   and the CPU I-flag is set, then waits for the ISR to write CLR_PORT.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   irq_src      : raw asynchronous request lines (rising-edge events)
//   intr_en      : CPU I-flag
//   port_id      : I/O port address
//   out_data     : OUT write data
//   io_strb      : OUT write strobe (one cycle)
//   in_data      : IN read data, combinational from port_id, 0 on no match
//   in_sel       : port_id addresses one of MASK/STAT/ID ports
//   interrupt    : registered request pulse to the control unit
module intr_ctrl
   import intr_pkg::*;
#(
   parameter int         N_SRC     = 8,
   parameter logic [7:0] MASK_PORT = MASK_PORT_DEF,
   parameter logic [7:0] CLR_PORT  = CLR_PORT_DEF,
   parameter logic [7:0] STAT_PORT = STAT_PORT_DEF,
   parameter logic [7:0] ID_PORT   = ID_PORT_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             intr_en,
   input  logic [7:0]       port_id,
   input  logic [7:0]       out_data,
   input  logic             io_strb,
   output logic [7:0]       in_data,
   output logic             in_sel,
   output logic             interrupt
);

   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] clr_bits;
   logic             req;
   logic             ack;
   state_t           state, state_nxt;

   // Per-source synchronizer and edge detector
   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      irq_sync_edge u_sync (
         .clk     (clk),
         .reset_n (reset_n),
         .src     (irq_src[g]),
         .rise    (rise[g])
      );
   end

   assign ack      = io_strb && (port_id == CLR_PORT);
   assign clr_bits = ack ? out_data[N_SRC-1:0] : '0;
   assign req      = (|(pending & mask)) & intr_en;

   // Pending/mask registers. A rise in the same cycle as a clear of that
   // bit wins, so an event arriving during the acknowledge is not lost.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending <= '0;
         mask    <= '0;
      end else begin
         pending <= (pending & ~clr_bits) | rise;
         if (io_strb && (port_id == MASK_PORT))
            mask <= out_data[N_SRC-1:0];
      end
   end

   // Request FSM: intr_en only gates leaving IDLE; ASSERT always moves on,
   // and SERVICE waits for any write to CLR_PORT.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_nxt = state;
      case (state)
         ST_IDLE:    if (req) state_nxt = ST_ASSERT;
         ST_ASSERT:  state_nxt = ST_SERVICE;
         ST_SERVICE: if (ack) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // 'interrupt' is registered alongside the state so it is high exactly
   // while the FSM sits in ASSERT.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         interrupt <= 1'b0;
      end else begin
         state     <= state_nxt;
         interrupt <= (state_nxt == ST_ASSERT);
      end
   end

   // IN read mux with lowest-index priority encoder
   logic [7:0] mask8;
   logic [7:0] act8;
   logic [2:0] idx;
   logic       valid;

   always_comb begin
      mask8 = '0;
      act8  = '0;
      mask8[N_SRC-1:0] = mask;
      act8[N_SRC-1:0]  = pending & mask;
      valid = |act8;
      idx   = 3'd0;
      // Scan downwards so the lowest set index is the last one written.
      for (int i = 7; i >= 0; i--) begin
         if (act8[i]) idx = 3'(i);
      end

      in_sel  = 1'b0;
      in_data = 8'h00;
      if (port_id == MASK_PORT) begin
         in_sel  = 1'b1;
         in_data = mask8;
      end else if (port_id == STAT_PORT) begin
         in_sel  = 1'b1;
         in_data = act8;
      end else if (port_id == ID_PORT) begin
         in_sel  = 1'b1;
         in_data = {valid, 4'b0000, idx};
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl -- directed self-checking bench for intr_ctrl.
//   Inputs change 1 time unit after a rising edge; outputs are sampled in
//   the same window, away from the active edge.
module tb_intr_ctrl;

   localparam logic [7:0] MASK_P = 8'h30;
   localparam logic [7:0] CLR_P  = 8'h31;
   localparam logic [7:0] STAT_P = 8'h32;
   localparam logic [7:0] ID_P   = 8'h33;

   logic       clk;
   logic       reset_n;
   logic [7:0] irq_src;
   logic       intr_en;
   logic [7:0] port_id;
   logic [7:0] out_data;
   logic       io_strb;
   logic [7:0] in_data;
   logic       in_sel;
   logic       interrupt;

   int checks = 0;
   int errors = 0;

   intr_ctrl dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .irq_src   (irq_src),
      .intr_en   (intr_en),
      .port_id   (port_id),
      .out_data  (out_data),
      .io_strb   (io_strb),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .interrupt (interrupt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One OUT write; consumes the edge at which the strobe is sampled.
   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      port_id  = addr;
      out_data = data;
      io_strb  = 1'b1;
      tick();
      io_strb  = 1'b0;
      out_data = 8'h00;
   endtask

   // Combinational IN read check; no clock edge consumed.
   task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      port_id = addr;
      #1;
      check(tag, in_data, exp);
      port_id = 8'h00;
   endtask

   task automatic chk_int(input string tag, input logic exp);
      check(tag, {7'b0, interrupt}, {7'b0, exp});
   endtask

   initial begin
      reset_n  = 1'b0;
      irq_src  = 8'h00;
      intr_en  = 1'b0;
      port_id  = 8'h00;
      out_data = 8'h00;
      io_strb  = 1'b0;

      // ---- Reset ----
      tick(2);
      chk_int("reset_int", 1'b0);
      rd("reset_mask", MASK_P, 8'h00);
      rd("reset_stat", STAT_P, 8'h00);
      rd("reset_id", ID_P, 8'h00);
      port_id = MASK_P; #1;
      check("in_sel_mask", {7'b0, in_sel}, 8'h01);
      port_id = 8'h10; #1;
      check("in_sel_none", {7'b0, in_sel}, 8'h00);
      check("in_data_none", in_data, 8'h00);
      port_id = CLR_P; #1;
      check("in_sel_clr", {7'b0, in_sel}, 8'h00);
      port_id = 8'h00;
      reset_n = 1'b1;
      tick();

      // ---- Basic request on source 2 ----
      wr(MASK_P, 8'h04);
      rd("basic_mask_rb", MASK_P, 8'h04);
      intr_en = 1'b1;
      irq_src[2] = 1'b1;       // before edge 0
      tick(3);                 // edges 0..2
      chk_int("basic_before_e3", 1'b0);
      tick();                  // edge 3
      chk_int("basic_pulse", 1'b1);
      rd("basic_id", ID_P, 8'h82);
      rd("basic_stat", STAT_P, 8'h04);
      tick();                  // edge 4
      chk_int("basic_pulse_end", 1'b0);
      tick(3);
      chk_int("basic_holdoff", 1'b0);
      wr(CLR_P, 8'h04);
      rd("basic_stat_clr", STAT_P, 8'h00);
      tick(3);
      chk_int("basic_no_repeat", 1'b0);
      irq_src[2] = 1'b0;

      // ---- Masked source 5 ----
      wr(MASK_P, 8'h00);
      irq_src[5] = 1'b1;
      tick(6);
      chk_int("masked_no_int", 1'b0);
      rd("masked_stat", STAT_P, 8'h00);
      rd("masked_id", ID_P, 8'h00);
      wr(MASK_P, 8'h20);
      chk_int("unmask_same_cycle", 1'b0);
      tick();
      chk_int("unmask_pulse", 1'b1);
      rd("unmask_id", ID_P, 8'h85);
      tick();
      chk_int("unmask_pulse_end", 1'b0);
      wr(CLR_P, 8'h20);
      irq_src[5] = 1'b0;
      tick(2);

      // ---- Hold-off and priority: sources 1 and 6 ----
      wr(MASK_P, 8'hFF);
      irq_src[1] = 1'b1;
      irq_src[6] = 1'b1;
      tick(3);
      chk_int("prio_before", 1'b0);
      tick();
      chk_int("prio_pulse1", 1'b1);
      rd("prio_id1", ID_P, 8'h81);
      rd("prio_stat1", STAT_P, 8'h42);
      tick();
      chk_int("prio_pulse1_end", 1'b0);
      irq_src[6] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_int("prio_service_lo", 1'b0);
      end
      irq_src[6] = 1'b1;       // re-raise while in SERVICE
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_int("prio_service_hi", 1'b0);
      end
      wr(CLR_P, 8'h02);
      chk_int("prio_ack_idle", 1'b0);
      rd("prio_id2", ID_P, 8'h86);
      tick();
      chk_int("prio_pulse2", 1'b1);
      tick();
      chk_int("prio_pulse2_end", 1'b0);
      wr(CLR_P, 8'h40);
      rd("prio_stat_clr", STAT_P, 8'h00);
      irq_src = 8'h00;
      tick(3);
      chk_int("prio_quiet", 1'b0);

      // ---- Clear/set collision on source 3 ----
      irq_src[3] = 1'b1;       // before edge 0
      tick(2);                 // edges 0, 1: rise now active
      wr(CLR_P, 8'h08);        // edge 2: set and clear together
      rd("coll_stat", STAT_P, 8'h08);
      tick();
      chk_int("coll_pulse", 1'b1);
      tick();
      chk_int("coll_pulse_end", 1'b0);
      wr(CLR_P, 8'h08);
      irq_src[3] = 1'b0;
      tick(2);

      // ---- intr_en gating ----
      intr_en = 1'b0;
      irq_src[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_int("gate_blocked", 1'b0);
      end
      rd("gate_stat", STAT_P, 8'h01);
      intr_en = 1'b1;
      tick();
      chk_int("gate_pulse", 1'b1);
      intr_en = 1'b0;          // must not abort SERVICE
      tick();
      chk_int("gate_pulse_end", 1'b0);
      irq_src[4] = 1'b1;
      tick(4);
      chk_int("gate_service", 1'b0);
      rd("gate_stat2", STAT_P, 8'h11);
      rd("gate_id", ID_P, 8'h80);

      // ---- Reset in SERVICE ----
      irq_src = 8'h00;
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick();
      chk_int("rst2_int", 1'b0);
      rd("rst2_mask", MASK_P, 8'h00);
      wr(MASK_P, 8'hFF);
      intr_en = 1'b1;
      rd("rst2_stat", STAT_P, 8'h00);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_int("rst2_no_pending", 1'b0);
      end
      irq_src[7] = 1'b1;
      tick(3);
      chk_int("rst2_before", 1'b0);
      tick();
      chk_int("rst2_idle_pulse", 1'b1);
      rd("rst2_id", ID_P, 8'h87);
      tick();
      chk_int("rst2_pulse_end", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
